// File: rtl/asrm_register_bank.sv
// Register bank and write-back stage for the asrm core: 16 architectural registers,
// a one-entry pending write stage with read forwarding, PC advance on retire, debug write port.
module asrm_register_bank #(
  parameter int unsigned         wordsize = 16,
  parameter logic [3:0]          pc_id    = 4'hF,
  parameter logic [3:0]          sr_id    = 4'hE,
  parameter logic [wordsize-1:0] reset_pc = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [3:0]          wb_reg,
  input  logic [wordsize-1:0] wb_data,
  input  logic                commit,
  input  logic                dbg_we,
  input  logic [3:0]          dbg_reg,
  input  logic [wordsize-1:0] dbg_data,
  input  logic [3:0]          other_idx,
  output logic [wordsize-1:0] working_register,
  output logic [wordsize-1:0] other_register,
  output logic [wordsize-1:0] status_register,
  output logic [wordsize-1:0] program_counter
);

  localparam logic [wordsize-1:0] pc_step = wordsize'(1);

  logic [wordsize-1:0] regs [16];

  logic                pend_valid;
  logic [3:0]          pend_reg;
  logic [wordsize-1:0] pend_data;

  logic                wb_accept;
  logic                wr_en;
  logic [3:0]          wr_reg;
  logic [wordsize-1:0] wr_data;
  logic                pc_write;
  logic                pend_load;
  logic                eff_commit;

  // Debug port owns the single write slot whenever it asks for it.
  assign wb_ready   = ~dbg_we;
  assign wb_accept  = wb_valid & wb_ready;
  assign wr_en      = dbg_we | wb_accept;
  assign wr_reg     = dbg_we ? dbg_reg  : wb_reg;
  assign wr_data    = dbg_we ? dbg_data : wb_data;
  assign pc_write   = wr_en & (wr_reg == pc_id);
  assign pend_load  = wr_en & ~pc_write;
  assign eff_commit = commit & (~wb_valid | wb_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_reg   <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= pend_load;
      if (pend_load) begin
        pend_reg  <= wr_reg;
        pend_data <= wr_data;
      end
    end
  end

  // The pending entry never holds pc_id, so the drain and the PC update never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      regs[pc_id] <= reset_pc;
    end else begin
      if (pend_valid) begin
        regs[pend_reg] <= pend_data;
      end
      if (pc_write) begin
        regs[pc_id] <= wr_data;
      end else if (eff_commit) begin
        regs[pc_id] <= regs[pc_id] + pc_step;
      end
    end
  end

  assign working_register = (pend_valid && pend_reg == 4'd0)      ? pend_data : regs[0];
  assign other_register   = (pend_valid && pend_reg == other_idx) ? pend_data : regs[other_idx];
  assign status_register  = (pend_valid && pend_reg == sr_id)     ? pend_data : regs[sr_id];
  assign program_counter  = regs[pc_id];

endmodule

// File: tb/tb_asrm_register_bank.sv
// Self-checking bench for asrm_register_bank: architectural model (writes visible the cycle
// after acceptance) compared every cycle, plus directed literal checks.
module tb_asrm_register_bank;

  localparam int unsigned    W      = 16;
  localparam logic [W-1:0]   RST_PC = 16'h0100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wb_valid, wb_ready, commit, dbg_we;
  logic [3:0]   wb_reg, dbg_reg, other_idx;
  logic [W-1:0] wb_data, dbg_data;
  logic [W-1:0] working_register, other_register, status_register, program_counter;

  always #5 clk = ~clk;

  asrm_register_bank #(
    .wordsize(W), .pc_id(4'hF), .sr_id(4'hE), .reset_pc(RST_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .commit(commit),
    .dbg_we(dbg_we), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
    .other_idx(other_idx),
    .working_register(working_register), .other_register(other_register),
    .status_register(status_register), .program_counter(program_counter)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  logic [W-1:0] m [16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[15] = RST_PC;
  endtask

  // Architectural model: every accepted write lands directly, PC steps on unstalled commit.
  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (!reset) begin
      model_reset();
    end else begin
      logic         we;
      logic [3:0]   r;
      logic [W-1:0] d;
      we = dbg_we || wb_valid;
      r  = dbg_we ? dbg_reg : wb_reg;
      d  = dbg_we ? dbg_data : wb_data;
      if (we && r == 4'hF) begin
        m[15] = d;
      end else begin
        if (commit && !(wb_valid && dbg_we)) m[15] = m[15] + 16'd1;
        if (we) m[r] = d;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wb_ready", {15'b0, wb_ready}, {15'b0, ~dbg_we});
      chk("working_register", working_register, m[0]);
      chk("other_register", other_register, m[other_idx]);
      chk("status_register", status_register, m[14]);
      chk("program_counter", program_counter, m[15]);
    end
  end

  task automatic idle();
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    commit = 1'b0;
    dbg_we = 1'b0; dbg_reg = '0; dbg_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    bit stalled;
    idle();
    other_idx = 4'd5;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", program_counter, 16'h0100);
    chk("rst_working", working_register, 16'h0000);
    chk("rst_status", status_register, 16'h0000);
    chk("rst_other5", other_register, 16'h0000);
    chk("rst_wb_ready", {15'b0, wb_ready}, 16'h0001);
    model_reset();
    cmp_en = 1'b1;
    reset = 1'b1;

    // Forwarding
    other_idx = 4'd3;
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'hBEEF;
    cyc();
    chk("fwd_r3", other_register, 16'hBEEF);
    cyc();
    chk("drain_r3", other_register, 16'hBEEF);
    wb_valid = 1'b1; wb_reg = 4'd0; wb_data = 16'h1234;
    cyc();
    chk("fwd_r0", working_register, 16'h1234);

    // Commit sequence from 0010
    dbg_we = 1'b1; dbg_reg = 4'hF; dbg_data = 16'h0010;
    cyc();
    chk("pc_set", program_counter, 16'h0010);
    for (int k = 1; k <= 3; k++) begin
      commit = 1'b1;
      cyc();
      chk("pc_commit", program_counter, 16'h0010 + 16'(k));
    end

    // Jump
    commit = 1'b1; wb_valid = 1'b1; wb_reg = 4'hF; wb_data = 16'h0400;
    cyc();
    chk("pc_jump", program_counter, 16'h0400);

    // Wrap
    dbg_we = 1'b1; dbg_reg = 4'hF; dbg_data = 16'hFFFF;
    cyc();
    commit = 1'b1;
    cyc();
    chk("pc_wrap", program_counter, 16'h0000);

    // Stall
    other_idx = 4'd2;
    dbg_we = 1'b1; dbg_reg = 4'd2; dbg_data = 16'h00AA;
    wb_valid = 1'b1; wb_reg = 4'd2; wb_data = 16'h0055; commit = 1'b1;
    #1;
    chk("stall_ready", {15'b0, wb_ready}, 16'h0000);
    cyc();
    chk("stall_pc", program_counter, 16'h0000);
    chk("stall_r2_dbg", other_register, 16'h00AA);
    wb_valid = 1'b1; wb_reg = 4'd2; wb_data = 16'h0055; commit = 1'b1;
    cyc();
    chk("unstall_pc", program_counter, 16'h0001);
    chk("unstall_r2", other_register, 16'h0055);

    // Back-to-back status writes
    wb_valid = 1'b1; wb_reg = 4'hE; wb_data = 16'h0001;
    cyc();
    chk("b2b_sr_1", status_register, 16'h0001);
    wb_valid = 1'b1; wb_reg = 4'hE; wb_data = 16'h0000;
    cyc();
    chk("b2b_sr_0", status_register, 16'h0000);
    cyc();
    chk("b2b_sr_final", status_register, 16'h0000);

    // Reset before the drain edge discards the pending write
    other_idx = 4'd7;
    wb_valid = 1'b1; wb_reg = 4'd7; wb_data = 16'h7777;
    cyc();
    chk("mid_r7_fwd", other_register, 16'h7777);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_r7_cleared", other_register, 16'h0000);
    chk("mid_pc_reset", program_counter, 16'h0100);

    // Randomized traffic; wb fields held while stalled
    stalled = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!stalled) begin
        wb_valid = 1'($urandom_range(0, 1));
        wb_reg   = 4'($urandom_range(0, 15));
        wb_data  = 16'($urandom);
      end
      dbg_we    = ($urandom_range(0, 7) == 0);
      dbg_reg   = 4'($urandom_range(0, 15));
      dbg_data  = 16'($urandom);
      commit    = 1'($urandom_range(0, 1));
      other_idx = 4'($urandom_range(0, 15));
      stalled   = wb_valid && dbg_we;
      @(posedge clk);
      #1;
    end
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asrm_register_bank.md
Name: asrm_register_bank

Overview:
- Register bank and write-back stage for the asrm core.
- Consumes the ALU result pair (data, destination register index) through a valid/ready handshake.
- Holds the 16 architectural registers. Supplies the working register, the selected other register, the status register and the program counter back to the ALU and fetch logic.
- Owns program-counter advance on instruction retire, plus a debug write port.

Parameters:
- wordsize, 16, width of every register and data port.
- pc_id, 4'hF, register index of the program counter.
- sr_id, 4'hE, register index of the status register.
- reset_pc, 0, program counter value after reset.

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_valid  input  1  ALU result presented.
- wb_ready  output  1  bank accepts result this cycle.
- wb_reg  input  4  destination register index.
- wb_data  input  wordsize  result value.
- commit  input  1  instruction retires this cycle.
- dbg_we  input  1  debug write request, priority over wb.
- dbg_reg  input  4  debug destination index.
- dbg_data  input  wordsize  debug write value.
- other_idx  input  4  index of other register to read.
- working_register  output  wordsize  register 0 (forwarded).
- other_register  output  wordsize  register other_idx (forwarded).
- status_register  output  wordsize  register sr_id (forwarded).
- program_counter  output  wordsize  register pc_id.

Behaviour:
- Reset (reset=0, asynchronous):
  - All 16 registers cleared to 0, then PC set to reset_pc.
  - Pending stage invalid.
  - All read outputs show 0, except program_counter, which shows reset_pc.
- Handshake:
  - wb_ready = ~dbg_we, combinational.
  - A wb write is accepted when wb_valid & wb_ready on a rising edge.
  - A debug write is accepted whenever dbg_we=1.
  - At most one write is accepted per cycle.
  - The source holds wb_valid/wb_reg/wb_data stable until accepted.
- Pending stage (one entry: pend_valid, pend_reg, pend_data):
  - An accepted write to any index other than pc_id is loaded into the pending stage at edge N.
  - At edge N+1 it drains into the array.
  - A new write loaded in the same cycle replaces it (drain and load in the same edge are both performed).
- Forwarding:
  - Each read output returns pend_data when pend_valid and pend_reg equals the read index. Otherwise it returns the array value.
  - Net latency: a write accepted at edge N is visible on read outputs from cycle N+1. There is no combinational path from wb_data to the read outputs.
  - Back-to-back writes to the same index: the later value wins from the cycle after its acceptance.
- Program counter:
  - Writes targeting pc_id bypass the pending stage and update PC directly at the accepting edge.
  - eff_commit = commit & (~wb_valid | wb_ready).
  - At an edge with eff_commit=1:
    - If an accepted write this edge targets pc_id, PC <= written value (jump). No increment.
    - Otherwise PC <= PC + 1, wrapping modulo 2^wordsize (all-ones -> 0).
  - PC write without commit: PC <= written value.
  - commit while wb stalled (wb_valid=1, dbg_we=1): no increment, and the wb write is not accepted.
- Register 0 and sr_id are ordinary storage. Only the index selects them; no special write rules.
- Reset asserted mid-operation discards the pending write. It does not reach the array.
- Writes to index 0..15 are all legal. There is no invalid index.

Test Plan:
- Reset: hold reset=0 with reset_pc=16'h0100 -> program_counter=16'h0100; working_register, status_register and other_register(idx 5) all 0; wb_ready=1.
- Forwarding: write r3=16'hBEEF at edge N with other_idx=3 -> other_register=16'hBEEF in cycle N+1 and still 16'hBEEF after drain; write r0=16'h1234 -> working_register=16'h1234 next cycle.
- Commit and jump:
  - Three commits with no PC write from PC=16'h0010 -> PC 0011, 0012, 0013.
  - Commit with wb_reg=4'hF, wb_data=16'h0400 -> PC=16'h0400, no increment.
  - PC=16'hFFFF, commit -> PC=16'h0000.
- Stall: dbg_we=1 (dbg_reg=2, dbg_data=16'h00AA) with wb_valid=1 (wb_reg=2, 16'h0055) and commit=1 -> wb_ready=0, PC unchanged, r2=16'h00AA. Next cycle with dbg_we=0 -> wb accepted, PC+1, r2=16'h0055.
- Back-to-back: sr_id written 16'h0001 then 16'h0000 on consecutive edges -> status_register reads 0001 then 0000, final array value 0000.
- Reset mid-operation: accept a write r7=16'h7777, assert reset before the drain edge -> r7 reads 0 after release.
